dm_store_buffer: RTL and testbench
==================================

// Module: dm_store_buffer
// PURPOSE
//  Write buffer between the MEM stage and the dm_4k data memory. Queues stores
//  from the pipeline and retires them into DM when the single DM address port
//  is free. Loads see the newest buffered value for their address, so a store
//  followed by a load never returns stale data. Lets a load-heavy sequence
//  proceed without a write-port conflict on every store.
// PARAMETERS
//  AW     5   word-address width; matches the DM addr port
//  DW     32  data width
//  DEPTH  4   buffer entries; must be a power of 2, at least 2
// PORTS
//  clk       in   1       clock; all state updates on the rising edge
//  rst       in   1       asynchronous, active-low reset
//  st_valid  in   1       MEM-stage store request this cycle
//  st_addr   in   AW      store word address
//  st_data   in   DW      store data
//  ld_req    in   1       MEM-stage load request this cycle
//  ld_addr   in   AW      load word address
//  flush     in   1       force drain every cycle until empty; loads that miss are stalled
//  ld_data   out  DW      load result, combinational, valid when ld_req & !stall
//  stall     out  1       MEM stage must hold its instruction this cycle
//  dm_addr   out  AW      to DM addr
//  dm_din    out  DW      to DM din
//  dm_wr     out  1       to DM DMWr
//  dm_rd     out  1       to DM DMemR
//  dm_dout   in   DW      from DM dout (combinational read)
//  empty     out  1       no valid entries
//  full      out  1       count == DEPTH
//  count     out  log2(DEPTH)+1   occupied entries
// BEHAVIOUR
//  Reset values: all entries invalid, wr_ptr = rd_ptr = 0, count = 0,
//   empty = 1, full = 0, stall = 0, dm_wr = 0, dm_rd = 0, ld_data = 0.
//  Storage is a circular FIFO. wr_ptr and rd_ptr wrap modulo DEPTH.
//  Forward hit (hit): ld_req, and some valid entry has addr == ld_addr.
//   The newest matching entry (closest to wr_ptr) supplies ld_data.
//  Drain condition (drain) = !empty & (flush | full | !ld_req | hit).
//   On a drain cycle: dm_wr = 1, dm_addr/dm_din = head entry, rd_ptr++ at the edge.
//  Load DM read: ld_req & !hit & !drain. Then dm_rd = 1, dm_addr = ld_addr,
//   ld_data = dm_dout.
//  Hit read: ld_data = buffered data; dm_rd = 0.
//  Idle (no drain, no DM read): dm_addr = 0, dm_wr = 0, dm_rd = 0.
//  stall = ld_req & !hit & drain.
//   The write wins the port and the load retries next cycle.
//   Stores never stall: when full, a drain always occurs, so st_valid is
//   accepted in the same cycle.
//  Store accept: the entry at wr_ptr is written, wr_ptr++.
//   count' = count + st_valid - drain.
//  Store and drain in the same cycle while full: legal; count stays DEPTH.
//  Store to an address already buffered: appended as a new entry, no merging.
//   DM receives both writes in program order.
//  ld_req and st_valid together is illegal from the pipeline.
//   If it happens, the store is accepted, stall = 0, and ld_data is don't-care.
//  A load never sees a store from the same cycle. Forwarding covers entries
//   present at the start of the cycle only.
//  flush: drains one entry per cycle until empty, and stalls loads that miss.
//   A hit load still completes.
//  Reset mid-operation: entries that have not drained are discarded.
//   DM keeps whatever was already written.
//  Latency: a store can be forwarded from the next cycle onward. It reaches DM
//   at the earliest 1 cycle after acceptance, when the port is free.
// STRUCTURE
//  Shared header dm_defs.vh: `DM_AW`, `DM_DW`, `SB_DEPTH` defaults.
//  One sub-module, sb_fwd_match: DEPTH-way address compare plus newest-first
//   priority select. Inputs are valid bits, addrs, data, wr_ptr and ld_addr.
//   Outputs are hit and data.
//  FIFO pointers, counter and DM port mux live in the top module.
// TESTING
//  1 st 0x03<-0xAAAA0001, then idle -> dm_wr=1 addr 0x03 din 0xAAAA0001 next cycle; empty=1 after.
//  2 st 0x05<-0x11, st 0x05<-0x22 under continuous misses on 0x09 -> ld 0x05 returns 0x22 (hit, stall=0).
//  3 4 stores with ld_req held (miss) -> full=1, drain, load stall=1 one cycle, then DM read completes.
//  4 full, st_valid & drain same cycle -> count stays 4, no stall, order preserved in DM writes.
//  5 flush with 3 entries plus a miss load -> 3 drain cycles with stall=1, then load served, empty=1.
//  6 rst low with 2 entries -> empty=1, count=0 immediately (async); dm_wr=0; no further DM writes.

Source files
------------

// File: rtl/dm_store_buffer_pkg.sv
// ---------------------------------------------------------------------------
// dm_store_buffer_pkg
//   Shared defaults and types for the MEM-stage store buffer that sits in
//   front of the dm_4k data memory.
//
//   DM_AW     default word-address width (matches the DM addr port)
//   DM_DW     default data width
//   SB_DEPTH  default number of buffer entries (power of 2, >= 2)
//   dm_port_e which client owns the single DM address port this cycle
// ---------------------------------------------------------------------------
package dm_store_buffer_pkg;

  localparam int unsigned DM_AW    = 5;
  localparam int unsigned DM_DW    = 32;
  localparam int unsigned SB_DEPTH = 4;

  // Owner of the DM address port for the current cycle.
  typedef enum logic [1:0] {
    PORT_IDLE  = 2'd0,  // nobody: address driven to zero
    PORT_WRITE = 2'd1,  // head entry retiring into DM
    PORT_READ  = 2'd2   // load that missed the buffer reads DM directly
  } dm_port_e;

endpackage

// File: rtl/dm_store_buffer_fwd_match.sv
// ---------------------------------------------------------------------------
// sb_fwd_match
//   Store-to-load forwarding lookup for dm_store_buffer. Compares ld_addr
//   against every buffered entry and returns the data of the newest valid
//   match, where "newest" means closest to (just behind) wr_ptr.
//
//   valid      in  DEPTH      per-entry valid bits
//   addrs      in  DEPTH*AW   entry word addresses, entry i at [i*AW +: AW]
//   entry_data in  DEPTH*DW   entry data, entry i at [i*DW +: DW]
//   wr_ptr     in  log2 DEPTH next slot to be written (one past newest)
//   ld_addr    in  AW         load word address
//   hit        out 1          some valid entry matches ld_addr
//   data       out DW         data of the newest matching entry, else 0
// ---------------------------------------------------------------------------
module sb_fwd_match #(
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic [DEPTH-1:0]         valid,
  input  logic [DEPTH*AW-1:0]      addrs,
  input  logic [DEPTH*DW-1:0]      entry_data,
  input  logic [$clog2(DEPTH)-1:0] wr_ptr,
  input  logic [AW-1:0]            ld_addr,
  output logic                     hit,
  output logic [DW-1:0]            data
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest-to-newest starting at wr_ptr (the oldest slot when full) so
  // that a later, younger match overwrites an earlier one; the last slot
  // visited is wr_ptr-1, the newest entry.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = wr_ptr + PW'(i);
      if (valid[idx] && (addrs[idx*AW +: AW] == ld_addr)) begin
        hit  = 1'b1;
        data = entry_data[idx*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/dm_store_buffer.sv
// ---------------------------------------------------------------------------
// dm_store_buffer
//   Write buffer between the MEM stage and the dm_4k data memory. Stores are
//   queued in a circular FIFO and retired into DM one per cycle whenever the
//   single DM address port is not needed by a load. Loads see the newest
//   buffered value for their address, so a store followed by a load never
//   returns stale data.
//
//   clk       in   clock, rising edge
//   rst       in   asynchronous, active-low reset
//   st_valid  in   store request this cycle
//   st_addr   in   store word address
//   st_data   in   store data
//   ld_req    in   load request this cycle
//   ld_addr   in   load word address
//   flush     in   drain every cycle until empty; missing loads stall
//   ld_data   out  load result (combinational), valid when ld_req & !stall
//   stall     out  MEM stage must hold its instruction this cycle
//   dm_addr   out  DM address
//   dm_din    out  DM write data
//   dm_wr     out  DM write enable
//   dm_rd     out  DM read enable
//   dm_dout   in   DM read data (combinational)
//   empty     out  no valid entries
//   full      out  count == DEPTH
//   count     out  occupied entries
// ---------------------------------------------------------------------------
module dm_store_buffer
  import dm_store_buffer_pkg::*;
#(
  parameter int unsigned AW    = DM_AW,
  parameter int unsigned DW    = DM_DW,
  parameter int unsigned DEPTH = SB_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  input  logic [AW-1:0]          st_addr,
  input  logic [DW-1:0]          st_data,
  input  logic                   ld_req,
  input  logic [AW-1:0]          ld_addr,
  input  logic                   flush,
  output logic [DW-1:0]          ld_data,
  output logic                   stall,
  output logic [AW-1:0]          dm_addr,
  output logic [DW-1:0]          dm_din,
  output logic                   dm_wr,
  output logic                   dm_rd,
  input  logic [DW-1:0]          dm_dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Entry storage, flattened so the forwarding block can take it as plain
  // vectors: entry i lives at [i*AW +: AW] / [i*DW +: DW].
  logic [DEPTH*AW-1:0] addr_q;
  logic [DEPTH*DW-1:0] data_q;
  logic [DEPTH-1:0]    valid_q;
  logic [PW-1:0]       wr_ptr_q;
  logic [PW-1:0]       rd_ptr_q;
  logic [CW-1:0]       count_q;

  logic                fwd_hit;
  logic [DW-1:0]       fwd_data;
  logic                ld_hit;
  logic                drain;
  dm_port_e            port_sel;

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  sb_fwd_match #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fwd (
    .valid      (valid_q),
    .addrs      (addr_q),
    .entry_data (data_q),
    .wr_ptr     (wr_ptr_q),
    .ld_addr    (ld_addr),
    .hit        (fwd_hit),
    .data       (fwd_data)
  );

  // Forwarding only looks at entries present at the start of the cycle, so a
  // same-cycle store is never visible to the load.
  assign ld_hit = ld_req & fwd_hit;

  // The port is free for a write unless a missing load needs it; full and
  // flush force the write regardless so stores can always be accepted.
  assign drain = !empty & (flush | full | !ld_req | ld_hit);

  // A load that misses while the write owns the port retries next cycle.
  // A load issued together with a store is not a legal pipeline request and
  // is never stalled, so the store is always taken.
  assign stall = ld_req & !ld_hit & drain & !st_valid;

  always_comb begin
    port_sel = PORT_IDLE;
    if (drain) begin
      port_sel = PORT_WRITE;
    end else if (ld_req && !ld_hit) begin
      port_sel = PORT_READ;
    end
  end

  always_comb begin
    dm_addr = '0;
    dm_din  = '0;
    dm_wr   = 1'b0;
    dm_rd   = 1'b0;
    unique case (port_sel)
      PORT_WRITE: begin
        dm_addr = addr_q[rd_ptr_q*AW +: AW];
        dm_din  = data_q[rd_ptr_q*DW +: DW];
        dm_wr   = 1'b1;
      end
      PORT_READ: begin
        dm_addr = ld_addr;
        dm_rd   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = '0;
    if (ld_hit) begin
      ld_data = fwd_data;
    end else if (port_sel == PORT_READ) begin
      ld_data = dm_dout;
    end
  end

  // When full, drain and store hit the same slot (rd_ptr == wr_ptr); the
  // store's valid set is issued last so it wins over the drain's clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      data_q   <= '0;
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (drain) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PW'(1);
      end
      if (st_valid) begin
        valid_q[wr_ptr_q]          <= 1'b1;
        addr_q[wr_ptr_q*AW +: AW]  <= st_addr;
        data_q[wr_ptr_q*DW +: DW]  <= st_data;
        wr_ptr_q                   <= wr_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(st_valid) - CW'(drain);
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_dm_store_buffer
//   Bench for dm_store_buffer. The environment provides a 32-word data memory
//   whose unwritten words read as 0xD000_0000 | addr. The reference model is
//   a queue of pending stores plus two memory images: exp_dm (what DM must
//   hold) and arch (what a load must observe, i.e. the newest store in
//   program order).
// ---------------------------------------------------------------------------
module tb_dm_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [4:0]  st_addr;
  logic [31:0] st_data;
  logic        ld_req;
  logic [4:0]  ld_addr;
  logic        flush;
  logic [31:0] ld_data;
  logic        stall;
  logic [4:0]  dm_addr;
  logic [31:0] dm_din;
  logic        dm_wr;
  logic        dm_rd;
  logic [31:0] dm_dout;
  logic        empty;
  logic        full;
  logic [2:0]  count;

  dm_store_buffer #(
    .AW    (5),
    .DW    (32),
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .ld_req   (ld_req),
    .ld_addr  (ld_addr),
    .flush    (flush),
    .ld_data  (ld_data),
    .stall    (stall),
    .dm_addr  (dm_addr),
    .dm_din   (dm_din),
    .dm_wr    (dm_wr),
    .dm_rd    (dm_rd),
    .dm_dout  (dm_dout),
    .empty    (empty),
    .full     (full),
    .count    (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- environment: data memory ----------------
  logic [31:0] dm_mem [32];
  logic [31:0] written = '0;

  function automatic logic [31:0] dm_init(input logic [4:0] a);
    return 32'hD000_0000 | 32'(a);
  endfunction

  always @(posedge clk) begin
    if (dm_wr) begin
      dm_mem[dm_addr]  <= dm_din;
      written[dm_addr] <= 1'b1;
    end
  end

  assign dm_dout = written[dm_addr] ? dm_mem[dm_addr] : dm_init(dm_addr);

  // ---------------- reference model + compare ----------------
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  ent_t        e;
  logic [31:0] exp_dm [32];
  logic [31:0] arch   [32];
  bit          model_init = 1'b0;
  bit          m_hit, m_drain, m_miss;

  always @(negedge clk) begin
    if (!model_init) begin
      for (int i = 0; i < 32; i++) exp_dm[i] = dm_init(5'(i));
      arch       = exp_dm;
      model_init = 1'b1;
    end
    if (!rst) begin
      q.delete();
      arch = exp_dm;
      check("rst_count", 32'(count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_dm_wr", 32'(dm_wr), 32'd0);
    end else begin
      m_hit = 1'b0;
      if (ld_req) begin
        foreach (q[i]) if (q[i].a == ld_addr) m_hit = 1'b1;
      end
      m_drain = (q.size() != 0) && (flush || q.size() == 4 || !ld_req || m_hit);
      m_miss  = ld_req && !m_hit;

      check("count", 32'(count), 32'(q.size()));
      check("empty", 32'(empty), 32'(q.size() == 0));
      check("full",  32'(full),  32'(q.size() == 4));
      check("dm_wr", 32'(dm_wr), 32'(m_drain));
      if (m_drain) begin
        check("drain_addr", 32'(dm_addr), 32'(q[0].a));
        check("drain_data", dm_din, q[0].d);
      end
      if (st_valid) begin
        check("stall_with_store", 32'(stall), 32'd0);
      end else begin
        check("stall", 32'(stall), 32'(m_miss && m_drain));
        check("dm_rd", 32'(dm_rd), 32'(m_miss && !m_drain));
        if (m_miss && !m_drain) check("rd_addr", 32'(dm_addr), 32'(ld_addr));
        if (ld_req && !(m_miss && m_drain)) check("ld_data", ld_data, arch[ld_addr]);
      end
      if (!m_drain && !ld_req) begin
        check("idle_addr", 32'(dm_addr), 32'd0);
        check("idle_rd", 32'(dm_rd), 32'd0);
      end

      if (m_drain) begin
        exp_dm[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (st_valid) begin
        e.a = st_addr;
        e.d = st_data;
        q.push_back(e);
        arch[st_addr] = st_data;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit s, input logic [4:0] sa, input logic [31:0] sd,
                       input bit l, input logic [4:0] la, input bit f);
    st_valid = s;
    st_addr  = sa;
    st_data  = sd;
    ld_req   = l;
    ld_addr  = la;
    flush    = f;
  endtask

  // One cycle: inputs change 1 time unit after the edge, literal checks can
  // follow at edge+3, the model compares at the falling edge.
  task automatic cyc(input bit s, input logic [4:0] sa, input logic [31:0] sd,
                     input bit l, input logic [4:0] la, input bit f);
    @(posedge clk);
    #1 drive(s, sa, sd, l, la, f);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 5'd0, 32'd0, 0, 5'd0, 0);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1 drive(0, 5'd0, 32'd0, 0, 5'd0, 0);
    #2 rst = 1'b0;
    #1;
    check("async_rst_empty", 32'(empty), 32'd1);
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_dm_wr", 32'(dm_wr), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  bit s, l, f;

  initial begin
    rst = 1'b0;
    drive(0, 5'd0, 32'd0, 0, 5'd0, 0);
    repeat (3) @(posedge clk);
    #3;
    check("reset_empty",   32'(empty),   32'd1);
    check("reset_full",    32'(full),    32'd0);
    check("reset_count",   32'(count),   32'd0);
    check("reset_stall",   32'(stall),   32'd0);
    check("reset_dm_wr",   32'(dm_wr),   32'd0);
    check("reset_dm_rd",   32'(dm_rd),   32'd0);
    check("reset_ld_data", ld_data,      32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // 1: single store retires on the following idle cycle
    cyc(1, 5'h03, 32'hAAAA_0001, 0, 5'd0, 0);
    check("t1_empty_before", 32'(empty), 32'd1);
    check("t1_no_wr_yet",    32'(dm_wr), 32'd0);
    cyc(0, 5'd0, 32'd0, 0, 5'd0, 0);
    check("t1_dm_wr",   32'(dm_wr),   32'd1);
    check("t1_dm_addr", 32'(dm_addr), 32'h03);
    check("t1_dm_din",  dm_din,       32'hAAAA_0001);
    cyc(0, 5'd0, 32'd0, 0, 5'd0, 0);
    check("t1_empty_after", 32'(empty), 32'd1);

    // 2: two stores to one address under misses on 0x09; newest forwarded
    cyc(1, 5'h05, 32'h11, 1, 5'h09, 0);
    cyc(1, 5'h05, 32'h22, 1, 5'h09, 0);
    cyc(0, 5'd0, 32'd0, 1, 5'h09, 0);
    check("t2_miss_data", ld_data, 32'hD000_0009);
    check("t2_miss_rd",   32'(dm_rd), 32'd1);
    cyc(0, 5'd0, 32'd0, 1, 5'h05, 0);
    check("t2_fwd_data",  ld_data, 32'h22);
    check("t2_fwd_stall", 32'(stall), 32'd0);
    cyc(0, 5'd0, 32'd0, 0, 5'd0, 0);
    check("t2_order_din", dm_din, 32'h22);
    idle(2);

    // 3: fill with a held miss, then the write wins the port for one cycle
    for (int i = 0; i < 4; i++) cyc(1, 5'(8'h10 + i), 32'h3000_0000 + i, 1, 5'h1A, 0);
    cyc(0, 5'd0, 32'd0, 1, 5'h1A, 0);
    check("t3_full",     32'(full),    32'd1);
    check("t3_stall",    32'(stall),   32'd1);
    check("t3_wr_addr",  32'(dm_addr), 32'h10);
    cyc(0, 5'd0, 32'd0, 1, 5'h1A, 0);
    check("t3_no_stall", 32'(stall),   32'd0);
    check("t3_rd",       32'(dm_rd),   32'd1);
    check("t3_ld_data",  ld_data,      32'hD000_001A);

    // 4: store while full: drain and accept in the same cycle
    cyc(1, 5'h14, 32'h3000_0004, 1, 5'h1A, 0);
    cyc(1, 5'h15, 32'h3000_0005, 0, 5'd0, 0);
    check("t4_full",    32'(full),    32'd1);
    check("t4_dm_addr", 32'(dm_addr), 32'h11);
    check("t4_stall",   32'(stall),   32'd0);
    cyc(0, 5'd0, 32'd0, 0, 5'd0, 0);
    check("t4_count",   32'(count),   32'd4);
    check("t4_next",    32'(dm_addr), 32'h12);
    idle(5);

    // 5: flush with three entries and a missing load
    for (int i = 0; i < 3; i++) cyc(1, 5'(8'h18 + i), 32'h5000_0000 + i, 1, 5'h1B, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 5'd0, 32'd0, 1, 5'h1B, 1);
      check("t5_stall", 32'(stall), 32'd1);
      check("t5_wr",    32'(dm_wr), 32'd1);
    end
    cyc(0, 5'd0, 32'd0, 1, 5'h1B, 1);
    check("t5_served", 32'(stall), 32'd0);
    check("t5_data",   ld_data,    32'hD000_001B);
    check("t5_empty",  32'(empty), 32'd1);

    // 6: reset discards two pending entries
    cyc(1, 5'h06, 32'h6666_0006, 1, 5'h1B, 0);
    cyc(1, 5'h07, 32'h6666_0007, 1, 5'h1B, 0);
    reset_pulse();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 5'd0, 32'd0, 0, 5'd0, 0);
      check("t6_no_wr", 32'(dm_wr), 32'd0);
    end

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) reset_pulse();
      s = ($urandom_range(0, 99) < 40);
      l = s ? ($urandom_range(0, 99) < 10) : ($urandom_range(0, 99) < 60);
      f = ($urandom_range(0, 99) < 8);
      cyc(s, rand_addr(), $urandom, l, rand_addr(), f);
    end
    idle(8);

    for (int i = 0; i < 32; i++)
      check("dm_image", written[i] ? dm_mem[i] : dm_init(5'(i)), exp_dm[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
